// File: rtl/bus6502_pkg.sv
// Shared types and constants for the 6502 memory responder.
package bus6502_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0]  OPEN_BUS = 8'hFF;
  localparam logic [15:0] VEC_LO   = 16'hFFFC;
  localparam logic [15:0] VEC_HI   = 16'hFFFD;

  // 17-bit differences give unsigned range tests that stay warning-free when base is 0.
  function automatic logic in_window(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] limit);
    logic [16:0] lo_d;
    logic [16:0] hi_d;
    lo_d = {1'b0, addr} - {1'b0, base};
    hi_d = {1'b0, limit} - {1'b0, addr};
    return !lo_d[16] && !hi_d[16];
  endfunction

endpackage

// File: rtl/bus6502_mem_resp_if.sv
// CPU-side and backend-side signals of the memory responder.
// Backend handshake: mem_req stays high with stable mem_addr/mem_we/mem_wdata until a
// single-cycle mem_ack pulse; mem_rdata is valid only in the mem_ack cycle.
interface bus6502_mem_resp_if;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        err_timeout;

  modport slave (
    input  cpu_ab, cpu_do, cpu_we, mem_ack, mem_rdata,
    output cpu_di, cpu_rdy, mem_req, mem_we, mem_addr, mem_wdata, err_timeout
  );

  modport master (
    output cpu_ab, cpu_do, cpu_we, mem_ack, mem_rdata,
    input  cpu_di, cpu_rdy, mem_req, mem_we, mem_addr, mem_wdata, err_timeout
  );
endinterface

// File: rtl/bus6502_wait_timer.sv
// Backend wait counter; term flags the edge on which the count reaches TIMEOUT.
module bus6502_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [7:0] count;

  assign term = en && (count == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'h00;
    end else if (clr) begin
      count <= 8'h00;
    end else if (en) begin
      count <= count + 8'h01;
    end
  end
endmodule

// File: rtl/bus6502_mem_resp.sv
// Answers 6502 bus cycles: reset vector locally, open bus outside the window,
// everything else through a stalled request/ack backend with timeout.
module bus6502_mem_resp
  import bus6502_pkg::*;
#(
  parameter logic [15:0] WIN_BASE  = 16'h0000,
  parameter logic [15:0] WIN_LIMIT = 16'hFFFB,
  parameter logic [15:0] RESET_VEC = 16'h0400,
  parameter int          TIMEOUT   = 16
) (
  input  logic                clk,
  input  logic                rst,
  bus6502_mem_resp_if.slave   bus,
  output state_t              dbg_state
);
  state_t      state;
  logic [7:0]  di_q;
  logic        rdy_q;
  logic        req_q;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        tmo_q;
  logic        tmr_term;
  logic        hit_win;

  assign hit_win = in_window(bus.cpu_ab, WIN_BASE, WIN_LIMIT);

  // Holding clear while idle leaves the count at zero on every BUSY entry.
  bus6502_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .en   ((state == BUSY) && !bus.mem_ack),
    .term (tmr_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      di_q    <= 8'h00;
      rdy_q   <= 1'b1;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rdy_q) begin
            if (!bus.cpu_we && bus.cpu_ab == VEC_LO) begin
              di_q <= RESET_VEC[7:0];
            end else if (!bus.cpu_we && bus.cpu_ab == VEC_HI) begin
              di_q <= RESET_VEC[15:8];
            end else if (hit_win) begin
              state   <= BUSY;
              req_q   <= 1'b1;
              rdy_q   <= 1'b0;
              addr_q  <= bus.cpu_ab;
              we_q    <= bus.cpu_we;
              wdata_q <= bus.cpu_do;
            end else if (!bus.cpu_we) begin
              di_q <= OPEN_BUS;
            end
          end
        end
        BUSY: begin
          // Ack wins over a timeout landing on the same edge.
          if (bus.mem_ack) begin
            state <= IDLE;
            req_q <= 1'b0;
            rdy_q <= 1'b1;
            if (!we_q) di_q <= bus.mem_rdata;
          end else if (tmr_term) begin
            state <= IDLE;
            req_q <= 1'b0;
            rdy_q <= 1'b1;
            tmo_q <= 1'b1;
            if (!we_q) di_q <= OPEN_BUS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_di      = di_q;
  assign bus.cpu_rdy     = rdy_q;
  assign bus.mem_req     = req_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.err_timeout = tmo_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_bus6502_mem_resp.sv
// Directed bench for bus6502_mem_resp: default instance plus a narrow-window instance.
module tb_bus6502_mem_resp;
  import bus6502_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t st1;
  state_t st2;
  int     chk_cnt = 0;
  int     pass_cnt = 0;

  bus6502_mem_resp_if bus ();
  bus6502_mem_resp_if bus2 ();

  bus6502_mem_resp dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(st1));

  bus6502_mem_resp #(.WIN_LIMIT(16'h7FFF)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .dbg_state(st2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle access: a write to FFFF is dropped by both instances.
  task automatic set_idle();
    bus.cpu_ab = 16'hFFFF; bus.cpu_we = 1'b1; bus.cpu_do = 8'h00;
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    bus2.cpu_ab = 16'hFFFF; bus2.cpu_we = 1'b1; bus2.cpu_do = 8'h00;
    bus2.mem_ack = 1'b0; bus2.mem_rdata = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.cpu_di, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err_timeout}
        !== {1'b1, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0})
      $display("FAIL reset_outputs: got rdy=%b di=%h req=%b we=%b addr=%h wd=%h err=%b want 1 00 0 0 0000 00 0",
               bus.cpu_rdy, bus.cpu_di, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.err_timeout);
    else pass_cnt++;
    chk_cnt++;
    if (st1 !== IDLE || st2 !== IDLE)
      $display("FAIL reset_state: got %0d/%0d want IDLE", st1, st2);
    else pass_cnt++;
  endtask

  task automatic test_vectors();
    bus.cpu_ab = 16'hFFFC; bus.cpu_we = 1'b0;
    rst = 1'b0;
    tick();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.cpu_di, bus.mem_req} !== {1'b1, 8'h00, 1'b0})
      $display("FAIL vec_lo: got rdy=%b di=%h req=%b want 1 00 0", bus.cpu_rdy, bus.cpu_di, bus.mem_req);
    else pass_cnt++;
    bus.cpu_ab = 16'hFFFD;
    tick();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.cpu_di, bus.mem_req} !== {1'b1, 8'h04, 1'b0})
      $display("FAIL vec_hi: got rdy=%b di=%h req=%b want 1 04 0", bus.cpu_rdy, bus.cpu_di, bus.mem_req);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_read_wait();
    bus.cpu_ab = 16'h0200; bus.cpu_we = 1'b0;
    tick();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_di} !== {1'b0, 1'b1, 1'b0, 16'h0200, 8'h04})
      $display("FAIL read_req: got rdy=%b req=%b we=%b addr=%h di=%h want 0 1 0 0200 04",
               bus.cpu_rdy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.cpu_di);
    else pass_cnt++;
    bus.cpu_ab = 16'h3333;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_cnt++;
      if ({bus.cpu_rdy, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 16'h0200})
        $display("FAIL read_hold: got rdy=%b req=%b addr=%h want 0 1 0200", bus.cpu_rdy, bus.mem_req, bus.mem_addr);
      else pass_cnt++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
    tick();
    set_idle();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di} !== {1'b1, 1'b0, 8'h5A})
      $display("FAIL read_done: got rdy=%b req=%b di=%h want 1 0 5a", bus.cpu_rdy, bus.mem_req, bus.cpu_di);
    else pass_cnt++;
  endtask

  task automatic test_write();
    bus.cpu_ab = 16'h0010; bus.cpu_we = 1'b1; bus.cpu_do = 8'hA5;
    tick();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b0, 1'b1, 1'b1, 16'h0010, 8'hA5})
      $display("FAIL write_req: got rdy=%b req=%b we=%b addr=%h wd=%h want 0 1 1 0010 a5",
               bus.cpu_rdy, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    else pass_cnt++;
    set_idle();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h33;
    tick();
    bus.mem_ack = 1'b0;
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di} !== {1'b1, 1'b0, 8'h5A})
      $display("FAIL write_done: got rdy=%b req=%b di=%h want 1 0 5a", bus.cpu_rdy, bus.mem_req, bus.cpu_di);
    else pass_cnt++;
  endtask

  task automatic test_timeout(input logic ack_at_end);
    bus.cpu_ab = 16'h1234; bus.cpu_we = 1'b0;
    tick();
    set_idle();
    for (int i = 1; i < 16; i++) begin
      tick();
      chk_cnt++;
      if ({bus.cpu_rdy, bus.mem_req, bus.err_timeout} !== {1'b0, 1'b1, 1'b0})
        $display("FAIL tmo_wait%0d: got rdy=%b req=%b err=%b want 0 1 0", i, bus.cpu_rdy, bus.mem_req, bus.err_timeout);
      else pass_cnt++;
    end
    bus.mem_ack = ack_at_end; bus.mem_rdata = 8'hC3;
    tick();
    bus.mem_ack = 1'b0;
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di, bus.err_timeout}
        !== {1'b1, 1'b0, (ack_at_end ? 8'hC3 : 8'hFF), !ack_at_end})
      $display("FAIL tmo_end ack=%b: got rdy=%b req=%b di=%h err=%b want 1 0 %h %b", ack_at_end,
               bus.cpu_rdy, bus.mem_req, bus.cpu_di, bus.err_timeout, (ack_at_end ? 8'hC3 : 8'hFF), !ack_at_end);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (bus.err_timeout !== 1'b0)
      $display("FAIL tmo_pulse: got err=%b want 0", bus.err_timeout);
    else pass_cnt++;
  endtask

  task automatic test_reset_busy();
    bus.cpu_ab = 16'h0200; bus.cpu_we = 1'b0;
    tick();
    set_idle();
    tick();
    #1 rst = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di, bus.mem_addr} !== {1'b1, 1'b0, 8'h00, 16'h0000} || st1 !== IDLE)
      $display("FAIL rst_busy: got rdy=%b req=%b di=%h addr=%h st=%0d want 1 0 00 0000 IDLE",
               bus.cpu_rdy, bus.mem_req, bus.cpu_di, bus.mem_addr, st1);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h77;
    tick();
    bus.mem_ack = 1'b0;
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di} !== {1'b1, 1'b0, 8'h00} || st1 !== IDLE)
      $display("FAIL stray_ack: got rdy=%b req=%b di=%h st=%0d want 1 0 00 IDLE", bus.cpu_rdy, bus.mem_req, bus.cpu_di, st1);
    else pass_cnt++;
    bus.cpu_ab = 16'h0300; bus.cpu_we = 1'b0;
    tick();
    chk_cnt++;
    if ({bus.mem_req, bus.mem_addr, bus.cpu_rdy} !== {1'b1, 16'h0300, 1'b0})
      $display("FAIL post_rst_req: got req=%b addr=%h rdy=%b want 1 0300 0", bus.mem_req, bus.mem_addr, bus.cpu_rdy);
    else pass_cnt++;
    set_idle();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h9C;
    tick();
    bus.mem_ack = 1'b0;
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di} !== {1'b1, 1'b0, 8'h9C})
      $display("FAIL post_rst_data: got rdy=%b req=%b di=%h want 1 0 9c", bus.cpu_rdy, bus.mem_req, bus.cpu_di);
    else pass_cnt++;
  endtask

  task automatic test_boundary();
    bus.cpu_ab = 16'hFFFB; bus.cpu_we = 1'b0;
    tick();
    chk_cnt++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 16'hFFFB})
      $display("FAIL limit_in: got req=%b addr=%h want 1 fffb", bus.mem_req, bus.mem_addr);
    else pass_cnt++;
    set_idle();
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
    tick();
    bus.cpu_ab = 16'hFFFE; bus.cpu_we = 1'b0; bus.mem_ack = 1'b0;
    tick();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di} !== {1'b1, 1'b0, 8'hFF})
      $display("FAIL open_bus: got rdy=%b req=%b di=%h want 1 0 ff", bus.cpu_rdy, bus.mem_req, bus.cpu_di);
    else pass_cnt++;
    bus.cpu_ab = 16'hFFFC; bus.cpu_we = 1'b1; bus.cpu_do = 8'h12;
    tick();
    chk_cnt++;
    if ({bus.cpu_rdy, bus.mem_req, bus.cpu_di} !== {1'b1, 1'b0, 8'hFF})
      $display("FAIL vec_write: got rdy=%b req=%b di=%h want 1 0 ff", bus.cpu_rdy, bus.mem_req, bus.cpu_di);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_window();
    bus2.cpu_ab = 16'h8000; bus2.cpu_we = 1'b0;
    tick();
    chk_cnt++;
    if ({bus2.cpu_rdy, bus2.mem_req, bus2.cpu_di} !== {1'b1, 1'b0, 8'hFF})
      $display("FAIL win_8000: got rdy=%b req=%b di=%h want 1 0 ff", bus2.cpu_rdy, bus2.mem_req, bus2.cpu_di);
    else pass_cnt++;
    bus2.cpu_ab = 16'h7FFF;
    tick();
    chk_cnt++;
    if ({bus2.cpu_rdy, bus2.mem_req, bus2.mem_addr} !== {1'b0, 1'b1, 16'h7FFF})
      $display("FAIL win_7fff: got rdy=%b req=%b addr=%h want 0 1 7fff", bus2.cpu_rdy, bus2.mem_req, bus2.mem_addr);
    else pass_cnt++;
    set_idle();
    bus2.mem_ack = 1'b1; bus2.mem_rdata = 8'h6E;
    tick();
    bus2.mem_ack = 1'b0;
    chk_cnt++;
    if ({bus2.cpu_rdy, bus2.mem_req, bus2.cpu_di} !== {1'b1, 1'b0, 8'h6E})
      $display("FAIL win_data: got rdy=%b req=%b di=%h want 1 0 6e", bus2.cpu_rdy, bus2.mem_req, bus2.cpu_di);
    else pass_cnt++;
  endtask

  initial begin
    set_idle();
    test_reset();
    test_vectors();
    test_read_wait();
    test_write();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_busy();
    test_boundary();
    test_window();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/bus6502_mem_resp.md
BUS6502_MEM_RESP -- requirements
Module: bus6502_mem_resp

Interface
REQ-001 Parameters SHALL be: WIN_BASE 16'h0000 (first address forwarded to backend); WIN_LIMIT 16'hFFFB (last address forwarded); RESET_VEC 16'h0400 (value returned for FFFC/FFFD); TIMEOUT 16 (max backend wait cycles, 1..255).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cpu_ab  input  16  CPU address; held stable by CPU while cpu_rdy=0.
REQ-005 cpu_do  input  8  CPU write data.
REQ-006 cpu_we  input  1  CPU write enable.
REQ-007 cpu_di  output  8  read data to CPU, registered.
REQ-008 cpu_rdy  output  1  CPU ready, registered; 0 stalls CPU.
REQ-009 mem_req  output  1  backend request, held until mem_ack.
REQ-010 mem_we  output  1  backend write.
REQ-011 mem_addr  output  16  backend address.
REQ-012 mem_wdata  output  8  backend write data.
REQ-013 mem_ack  input  1  backend completion, single-cycle pulse.
REQ-014 mem_rdata  input  8  backend read data, valid with mem_ack.
REQ-015 err_timeout  output  1  one-cycle pulse on backend timeout.

Function
REQ-016 Every rising edge with state IDLE and cpu_rdy=1 SHALL sample (cpu_ab, cpu_we, cpu_do) as one CPU access; the CPU issues an access every cycle.
REQ-017 Access to FFFC/FFFD (read) SHALL complete without backend: next cycle cpu_di = RESET_VEC[7:0] / RESET_VEC[15:8], cpu_rdy stays 1.
REQ-018 Access outside WIN_BASE..WIN_LIMIT (excluding REQ-017) SHALL complete without backend: reads give cpu_di=8'hFF next cycle, writes dropped, cpu_rdy stays 1.
REQ-019 Access inside window SHALL enter BUSY: next cycle mem_req=1, mem_addr/mem_we/mem_wdata = sampled values, cpu_rdy=0, cpu_di unchanged.
REQ-020 In BUSY, mem_ack=1 at an edge SHALL return to IDLE: next cycle mem_req=0, cpu_rdy=1, cpu_di=mem_rdata for reads, cpu_di unchanged for writes.
REQ-021 Minimum in-window latency SHALL be 2 cycles (request edge to cpu_rdy=1 with data) when mem_ack arrives on the first BUSY cycle.
REQ-022 Wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; when it reaches TIMEOUT without ack, next cycle: IDLE, mem_req=0, cpu_rdy=1, cpu_di=8'hFF (reads), err_timeout=1 for exactly one cycle.
REQ-023 mem_ack on the same edge the counter reaches TIMEOUT SHALL be treated as normal completion; no err_timeout.
REQ-024 mem_ack while IDLE SHALL be ignored (no state, data or output change).
REQ-025 mem_addr/mem_we/mem_wdata SHALL be stable throughout BUSY; cpu_ab changes during BUSY SHALL be ignored.
REQ-026 States SHALL be exactly IDLE and BUSY; no other transitions than REQ-019/020/022.

Reset
REQ-027 Asserting rst SHALL immediately force: state IDLE, cpu_rdy=1, cpu_di=8'h00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, err_timeout=0, wait counter 0.
REQ-028 Reset during BUSY SHALL abandon the backend access; a later stray mem_ack SHALL be ignored per REQ-024.
REQ-029 First edge after rst deassertion SHALL sample a new access per REQ-016.

Structure
REQ-030 Package bus6502_pkg SHALL hold the state enum (IDLE, BUSY), OPEN_BUS=8'hFF, VEC_LO=16'hFFFC, VEC_HI=16'hFFFD.
REQ-031 Wait counter with terminal flag SHALL be sub-module bus6502_wait_timer (clear, enable, terminal at TIMEOUT); all else in one module.

Verification
REQ-032 Reset release, cpu_ab=FFFC then FFFD, no backend activity -> cpu_di=8'h00 then 8'h04, cpu_rdy=1 throughout, mem_req=0.
REQ-033 Read 16'h0200, ack 3 cycles after mem_req rises with mem_rdata=8'h5A -> cpu_rdy=0 for 3 cycles, then cpu_rdy=1 and cpu_di=8'h5A; mem_addr=0200 whole BUSY.
REQ-034 Write 16'h0010 data 8'hA5, ack first BUSY cycle -> mem_we=1, mem_wdata=A5 one cycle, cpu_rdy low exactly 1 cycle, cpu_di unchanged.
REQ-035 Read 16'h1234, no ack, TIMEOUT=16 -> cpu_rdy=0 for 16 cycles, then cpu_di=8'hFF, err_timeout single pulse; ack exactly at 16th cycle variant -> normal data, no pulse.
REQ-036 Assert rst on 2nd BUSY cycle, then stray mem_ack after release -> outputs at reset values, stray ack ignored, next access proceeds normally.
REQ-037 WIN_LIMIT=16'h7FFF, read 16'h8000 -> cpu_di=8'hFF next cycle, no mem_req, cpu_rdy stays 1.
